wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 2, meaning store-buffer entry count (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have inputs in_reg_write 1, in_mem_write 1, in_dest 5, in_imm 8, in_acc_data 8, in_mem_data 8, in_reg_data 8 and in_opcode 3, all driven by the MEM/WB pipeline register.
REQ-005 SHALL have outputs rf_we 1, rf_waddr 5 and rf_wdata 8, forming the register-file write port.
REQ-006 SHALL have output acc_out 8, the architectural accumulator.
REQ-007 SHALL have outputs mem_req 1, mem_addr 8 and mem_wdata 8, plus input mem_ack 1, forming the data-memory store port.
REQ-008 SHALL have output stall 1, meaning the current WB instruction is not consumed and upstream holds its inputs.

Function
REQ-009 SHALL decode in_opcode as follows: 000 NOP; 001, 010 and 110 are REG class; 011 is STORE class; 100, 101 and 111 are ACC class.
REQ-010 SHALL, for REG class, drive rf_we=in_reg_write, rf_waddr=in_dest and rf_wdata=in_reg_data combinationally in the same cycle.
REQ-011 SHALL hold rf_we=0 for every non-REG class and while stall=1.
REQ-012 SHALL, for ACC class with in_reg_write=1, load acc_out<=in_acc_data at the next edge; otherwise acc_out holds.
REQ-013 SHALL, for STORE class with in_mem_write=1 and stall=0, push {in_imm, in_mem_data} into a FIFO store buffer at the edge.
REQ-014 SHALL treat STORE class with in_mem_write=0 as a NOP.
REQ-015 SHALL drive stall=1 combinationally iff the buffer is full (count==SB_DEPTH) and the incoming instruction is a STORE with in_mem_write=1; there is no same-cycle pop bypass.
REQ-016 SHALL drive stall=0 for non-STORE instructions even when the buffer is full.
REQ-017 SHALL assert mem_req=1 iff the buffer is non-empty, with mem_addr and mem_wdata taken from the head entry.
REQ-018 SHALL keep mem_req, mem_addr and mem_wdata stable while mem_req=1 and mem_ack=0.
REQ-019 SHALL pop the head entry at the edge where mem_req=1 and mem_ack=1.
REQ-020 SHALL ignore mem_ack while mem_req=0.
REQ-021 SHALL leave count unchanged on a simultaneous push and pop; the new entry goes to the tail and order is preserved.
REQ-022 SHALL wrap the read and write pointers modulo SB_DEPTH; count is a separate ceil(log2(SB_DEPTH+1))-bit counter.
REQ-023 SHALL guarantee, after a push into an empty buffer, that mem_req rises in the following cycle, i.e. one cycle of latency.
REQ-024 SHALL emit stores to memory strictly in program order, never merged or dropped.
REQ-025 SHALL leave a NOP with no side effects.

Reset
REQ-026 SHALL, when rst=0, asynchronously clear acc_out, the buffer pointers and count to 0.
REQ-027 SHALL, during reset, force mem_req=0, mem_addr=0, mem_wdata=0, rf_we=0 and stall=0.
REQ-028 SHALL treat reset mid-handshake as discarding all pending stores; mem_req drops immediately with no outstanding transaction retained.
REQ-029 SHALL perform no push, pop or ACC load on the first edge after rst deasserts unless the inputs request one.

Structure
REQ-030 SHALL place the opcode encodings (OP_NOP, OP_REG0/1/2, OP_STORE, OP_ACC0/1/2) and the data and address widths in a shared package also used by the decode and MEM stages.
REQ-031 SHALL implement the store buffer as one sub-module, wb_store_fifo (parameter SB_DEPTH; push/pop, full/empty, count), instantiated once.
REQ-032 SHALL keep the class decode, the ACC register and the RF port logic in wb_stage.

Verification
REQ-033 SHALL cover: opcode 001, reg_write=1, dest=5, reg_data=8'h3C -> rf_we=1, rf_waddr=5, rf_wdata=8'h3C in the same cycle, with acc_out unchanged.
REQ-034 SHALL cover: opcode 100, reg_write=1, acc_data=8'hA5 -> acc_out=8'hA5 after one edge; then opcode 101 with reg_write=0 -> acc_out stays 8'hA5.
REQ-035 SHALL cover: mem_ack tied 0; stores (imm 8'h10, data 8'h11) and (8'h20, 8'h22) -> mem_req=1 with addr 8'h10 held; a third store -> stall=1 for as long as mem_ack=0.
REQ-036 SHALL cover: from the full state, pulse mem_ack one cycle while a store (8'h30, 8'h33) waits -> pop 8'h10 releases stall the next cycle; stores then complete in order 8'h20 then 8'h30.
REQ-037 SHALL cover: count=1 with a simultaneous push and ack -> count remains 1 and the head advances to the new entry.
REQ-038 SHALL cover: rst pulled low while mem_req=1 and mem_ack=0 -> mem_req=0 and acc_out=0 immediately, without waiting for a clock edge; after release, no stale store reappears.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared definitions for the back end of the pipeline: opcode encodings,
// datapath widths and the store-buffer entry layout.
package wb_stage_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int REG_AW = 5;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'b000,
    OP_REG0  = 3'b001,
    OP_REG1  = 3'b010,
    OP_STORE = 3'b011,
    OP_ACC0  = 3'b100,
    OP_ACC1  = 3'b101,
    OP_REG2  = 3'b110,
    OP_ACC2  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_REG,
    CLS_STORE,
    CLS_ACC
  } op_class_e;

  // One pending store: address comes from the immediate field
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

  // Collapse the raw opcode into the class that selects the WB side effect
  function automatic op_class_e decode_class(input logic [OP_W-1:0] op);
    op_class_e cls;
    case (op)
      OP_REG0, OP_REG1, OP_REG2: cls = CLS_REG;
      OP_STORE:                  cls = CLS_STORE;
      OP_ACC0, OP_ACC1, OP_ACC2: cls = CLS_ACC;
      default:                   cls = CLS_NOP;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/wb_store_fifo.sv
// Store buffer: small FIFO of {addr, data} entries draining to data memory.
// Pointers wrap naturally (power-of-two depth); occupancy is a separate
// counter so full and empty are unambiguous.
module wb_store_fifo
  import wb_stage_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  sb_entry_t                         wr_entry,
  input  logic                              pop,
  output sb_entry_t                         rd_entry,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(SB_DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH+1);

  sb_entry_t        mem [SB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(SB_DEPTH));
  assign empty   = (count == '0);
  // Overflow/underflow requests are dropped rather than corrupting state
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Head entry reads as zero when nothing is queued, so the memory port
  // shows clean zeros after reset without resetting the storage itself
  assign rd_entry = empty ? '0 : mem[rd_ptr];

  // Entry storage; contents are only meaningful between rd_ptr and wr_ptr
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  // Pointer and occupancy bookkeeping; reset discards everything queued
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Caller contract: never push into a full buffer or pop an empty one
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) !(pop && empty));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: retires the instruction in MEM/WB into the register
// file, the accumulator, or the store buffer that drains to data memory.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int SB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_reg_write,
  input  logic              in_mem_write,
  input  logic [REG_AW-1:0] in_dest,
  input  logic [ADDR_W-1:0] in_imm,
  input  logic [DATA_W-1:0] in_acc_data,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_reg_data,
  input  logic [OP_W-1:0]   in_opcode,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] acc_out,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              stall
);

  op_class_e cls;
  logic      store_req;
  logic      sb_push;
  logic      sb_pop;
  logic      sb_full;
  logic      sb_empty;
  sb_entry_t sb_wr;
  sb_entry_t sb_head;

  assign cls       = decode_class(in_opcode);
  // A STORE without mem_write retires as a NOP
  assign store_req = (cls == CLS_STORE) & in_mem_write;

  // Stall only the store that cannot enter a full buffer; a pop on the same
  // edge does not free a slot for it (no bypass), so it waits one cycle.
  // Reset masks the handshake outputs combinationally.
  assign stall   = rst & store_req & sb_full;
  assign sb_push = store_req & ~sb_full;
  assign sb_pop  = mem_req & mem_ack;
  assign sb_wr   = '{addr: in_imm, data: in_mem_data};

  // Register-file port is purely combinational from the MEM/WB register
  assign rf_we    = rst & (cls == CLS_REG) & in_reg_write & ~stall;
  assign rf_waddr = in_dest;
  assign rf_wdata = in_reg_data;

  // Memory port mirrors the buffer head; it only changes on a pop or
  // when the buffer goes from empty to non-empty, which keeps it stable
  // for the whole req/ack handshake
  assign mem_req   = ~sb_empty;
  assign mem_addr  = sb_head.addr;
  assign mem_wdata = sb_head.data;

  // Architectural accumulator, loaded by ACC-class ops with reg_write set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_out <= '0;
    end else if ((cls == CLS_ACC) && in_reg_write) begin
      acc_out <= in_acc_data;
    end
  end

  wb_store_fifo #(
    .SB_DEPTH (SB_DEPTH)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .push     (sb_push),
    .wr_entry (sb_wr),
    .pop      (sb_pop),
    .rd_entry (sb_head),
    .full     (sb_full),
    .empty    (sb_empty),
    .count    ()
  );

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a vector table for the REG/ACC/NOP
// paths and a store-buffer scoreboard for the memory port.
module tb_wb_stage;

  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_reg_write, in_mem_write;
  logic [4:0] in_dest;
  logic [7:0] in_imm, in_acc_data, in_mem_data, in_reg_data;
  logic [2:0] in_opcode;
  logic       rf_we;
  logic [4:0] rf_waddr;
  logic [7:0] rf_wdata, acc_out, mem_addr, mem_wdata;
  logic       mem_req, mem_ack, stall;

  int checks = 0;
  int errors = 0;

  wb_stage #(.SB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_reg_write(in_reg_write), .in_mem_write(in_mem_write),
    .in_dest(in_dest), .in_imm(in_imm), .in_acc_data(in_acc_data),
    .in_mem_data(in_mem_data), .in_reg_data(in_reg_data), .in_opcode(in_opcode),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .acc_out(acc_out),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic [2:0] op, input logic rw, input logic mw,
                        input logic [4:0] dest, input logic [7:0] imm,
                        input logic [7:0] ad, input logic [7:0] md, input logic [7:0] rd);
    in_opcode = op; in_reg_write = rw; in_mem_write = mw; in_dest = dest;
    in_imm = imm; in_acc_data = ad; in_mem_data = md; in_reg_data = rd;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] d);
    set_in(3'b011, 1'b0, 1'b1, 5'd0, a, 8'h00, d, 8'h00);
  endtask

  task automatic nop();
    set_in(3'b000, 1'b0, 1'b0, 5'd0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  // Scoreboard: a reference occupancy count and a queue of expected stores.
  // Evaluated on the falling edge, when inputs and outputs are settled.
  logic [15:0] sbq[$];
  int          mcount = 0;
  logic        m_store, m_push, m_pop;

  always @(negedge clk) begin
    if (!rst) begin
      sbq.delete();
      mcount = 0;
    end else begin
      m_store = (in_opcode == 3'b011) && in_mem_write;
      chk("sb_stall", stall, m_store && (mcount == DEPTH));
      chk("sb_mem_req", mem_req, mcount != 0);
      if (mcount != 0 && sbq.size() > 0) chk("sb_head", {mem_addr, mem_wdata}, sbq[0]);
      m_pop  = (mcount != 0) && mem_ack;
      m_push = m_store && (mcount < DEPTH);
      if (m_pop) void'(sbq.pop_front());
      if (m_push) sbq.push_back({in_imm, in_mem_data});
      mcount = mcount + int'(m_push) - int'(m_pop);
    end
  end

  typedef struct {
    logic [2:0] op;
    logic       rw;
    logic       mw;
    logic [4:0] dest;
    logic [7:0] rd;
    logic [7:0] ad;
    logic       ewe;
    logic [7:0] eacc;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #20000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a REG write presented: the RF port must stay quiet
    rst = 1'b0; mem_ack = 1'b0;
    set_in(3'b001, 1'b1, 1'b0, 5'd7, 8'h00, 8'h00, 8'h00, 8'h55);
    #1;
    chk("rst_rf_we", rf_we, 1'b0);
    chk("rst_acc", acc_out, 8'h00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", {mem_addr, mem_wdata}, 16'h0000);
    chk("rst_stall", stall, 1'b0);
    nop();
    @(posedge clk); #1 rst = 1'b1;
    tick();

    //          op    rw  mw  dest   rd     ad     ewe eacc
    vecs[0] = '{3'd1, 1, 0, 5'd5,  8'h3C, 8'h00, 1, 8'h00};
    vecs[1] = '{3'd4, 1, 0, 5'd0,  8'h00, 8'hA5, 0, 8'hA5};
    vecs[2] = '{3'd5, 0, 0, 5'd0,  8'h00, 8'h77, 0, 8'hA5};
    vecs[3] = '{3'd2, 1, 0, 5'h1F, 8'hFF, 8'h12, 1, 8'hA5};
    vecs[4] = '{3'd6, 0, 0, 5'd3,  8'h44, 8'h13, 0, 8'hA5};
    vecs[5] = '{3'd0, 1, 1, 5'd4,  8'h66, 8'h11, 0, 8'hA5};
    vecs[6] = '{3'd7, 1, 0, 5'd0,  8'h00, 8'h5A, 0, 8'h5A};
    vecs[7] = '{3'd3, 1, 0, 5'd2,  8'h21, 8'h33, 0, 8'h5A};
    vecs[8] = '{3'd6, 1, 0, 5'd0,  8'h00, 8'h00, 1, 8'h5A};
    vecs[9] = '{3'd5, 1, 0, 5'd9,  8'h01, 8'h00, 0, 8'h00};

    for (int i = 0; i < 10; i++) begin
      set_in(vecs[i].op, vecs[i].rw, vecs[i].mw, vecs[i].dest, 8'hEE,
             vecs[i].ad, 8'hDD, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_rf_we", i), rf_we, vecs[i].ewe);
      if (vecs[i].ewe) begin
        chk($sformatf("v%0d_rf_waddr", i), rf_waddr, vecs[i].dest);
        chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].rd);
      end
      tick();
      chk($sformatf("v%0d_acc", i), acc_out, vecs[i].eacc);
    end
    nop(); tick();

    // Fill the buffer with memory never acknowledging
    mem_ack = 1'b0;
    store(8'h10, 8'h11);
    @(negedge clk); chk("fill_latency_req", mem_req, 1'b0);
    tick();
    store(8'h20, 8'h22);
    @(negedge clk); chk("fill_req", mem_req, 1'b1); chk("fill_addr", mem_addr, 8'h10);
    tick();
    store(8'h30, 8'h33);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("full_stall", stall, 1'b1); chk("full_addr_held", mem_addr, 8'h10);
      chk("full_rf_we", rf_we, 1'b0);
      tick();
    end
    // One ack while the third store waits: no same-cycle bypass
    mem_ack = 1'b1;
    @(negedge clk); chk("ack_still_stall", stall, 1'b1);
    tick();
    mem_ack = 1'b0;
    @(negedge clk); chk("released_stall", stall, 1'b0); chk("released_head", mem_addr, 8'h20);
    tick();
    nop(); mem_ack = 1'b1;
    @(negedge clk); chk("drain_first", {mem_addr, mem_wdata}, 16'h2022);
    tick();
    @(negedge clk); chk("drain_second", {mem_addr, mem_wdata}, 16'h3033);
    tick();
    mem_ack = 1'b0;
    @(negedge clk); chk("drained_req", mem_req, 1'b0);
    tick();

    // count==1 with simultaneous push and pop
    store(8'h40, 8'h44); tick();
    store(8'h50, 8'h55); mem_ack = 1'b1;
    @(negedge clk); chk("pp_head_old", mem_addr, 8'h40);
    tick();
    nop(); mem_ack = 1'b0;
    @(negedge clk);
    chk("pp_count", 32'(dut.u_sb.count), 32'd1);
    chk("pp_head_new", {mem_addr, mem_wdata}, 16'h5055);
    tick();
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    @(negedge clk); chk("pp_empty", mem_req, 1'b0);
    tick();

    // Reset in the middle of an outstanding handshake
    set_in(3'b100, 1'b1, 1'b0, 5'd0, 8'h00, 8'h99, 8'h00, 8'h00); tick();
    store(8'h60, 8'h66); tick();
    store(8'h70, 8'h77);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_acc", acc_out, 8'h00);
    chk("mid_rst_addr", {mem_addr, mem_wdata}, 16'h0000);
    set_in(3'b010, 1'b1, 1'b0, 5'd1, 8'h00, 8'h00, 8'h00, 8'h12);
    #1 chk("mid_rst_rf_we", rf_we, 1'b0);
    nop(); mem_ack = 1'b1;
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("post_rst_no_stale", mem_req, 1'b0);
      tick();
    end
    chk("post_rst_acc", acc_out, 8'h00);
    mem_ack = 1'b0;
    store(8'h80, 8'h88); tick();
    nop();
    @(negedge clk); chk("post_rst_store", {mem_req, mem_addr, mem_wdata}, {1'b1, 16'h8088});
    tick();
    mem_ack = 1'b1; tick();
    mem_ack = 1'b0;
    @(negedge clk); chk("final_empty", mem_req, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
